inst_encoder: RTL and testbench

Sequential LEGv8 instruction encoder and program loader. Accepts one symbolic instruction per handshake (operation select plus register and immediate fields), packs it into the 32-bit machine word expected by the CPU control decoder and datapath, and writes it into instruction memory at consecutive word addresses. Sits between the testbench or boot loader and the instruction memory. It is the write/encode side of the opcode map that `cpu_control` decodes.

---
 rtl/inst_encoder_if.sv | 31 +++
 rtl/inst_encoder.sv | 185 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Handshake and memory-write bundle for the LEGv8 instruction encoder.
// The master side supplies symbolic instructions and observes the write
// strobe and status flags; the slave side is the encoder itself.
interface inst_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [25:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-2:0] count;
  logic              done;
  logic              err_op;
  logic              err_range;

  modport master (
    output in_valid, op, rd, rn, rm, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, done, err_op, err_range
  );

  modport slave (
    input  in_valid, op, rd, rn, rm, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, done, err_op, err_range
  );
endinterface

// File: rtl/inst_encoder.sv
// Sequential LEGv8 instruction encoder and program loader.
// Accepts one symbolic instruction per handshake, packs it into the 32-bit
// machine word understood by cpu_control, and writes it to instruction
// memory at consecutive word addresses. Each instruction walks
// IDLE -> ENC -> WR; HALT or a full memory parks the block in DONE.
module inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input logic           clk,
  input logic           reset,
  inst_encoder_if.slave bus
);

  localparam logic [3:0] OP_LDUR = 4'd0;
  localparam logic [3:0] OP_STUR = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_ORR  = 4'd6;
  localparam logic [3:0] OP_CBZ  = 4'd7;
  localparam logic [3:0] OP_CBNZ = 4'd8;
  localparam logic [3:0] OP_B    = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd10;

  // Last word-aligned byte address; writing here fills the memory.
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENC,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rn_q, rn_d;
  logic [4:0]        rm_q, rm_d;
  logic [25:0]       imm_q, imm_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-2:0] count_q, count_d;
  logic              errOp_q, errOp_d;
  logic              errRange_q, errRange_d;

  logic [31:0]       encWord;
  logic              encRangeBad;
  logic              encIllegal;

  // Pack the captured fields into a machine word and flag fields that do not fit.
  always_comb begin
    encWord     = 32'h0000_0000;
    encRangeBad = 1'b0;
    encIllegal  = 1'b0;
    case (op_q)
      OP_LDUR: begin
        encWord     = {11'b11111000010, imm_q[8:0], 2'b00, rn_q, rd_q};
        encRangeBad = |imm_q[25:9];
      end
      OP_STUR: begin
        encWord     = {11'b11111000000, imm_q[8:0], 2'b00, rn_q, rd_q};
        encRangeBad = |imm_q[25:9];
      end
      OP_ADD:  encWord = {11'b10001011000, rm_q, 6'b000000, rn_q, rd_q};
      OP_SUB:  encWord = {11'b11001011000, rm_q, 6'b000000, rn_q, rd_q};
      OP_AND:  encWord = {11'b10001010000, rm_q, 6'b000000, rn_q, rd_q};
      OP_ORR:  encWord = {11'b10101010000, rm_q, 6'b000000, rn_q, rd_q};
      OP_ADDI: begin
        encWord     = {10'b1001000100, imm_q[11:0], rn_q, rd_q};
        encRangeBad = |imm_q[25:12];
      end
      OP_CBZ: begin
        encWord     = {8'b10110100, imm_q[18:0], rd_q};
        encRangeBad = !((&imm_q[25:18]) || !(|imm_q[25:18]));
      end
      OP_CBNZ: begin
        encWord     = {8'b10110101, imm_q[18:0], rd_q};
        encRangeBad = !((&imm_q[25:18]) || !(|imm_q[25:18]));
      end
      OP_B:    encWord = {6'b000101, imm_q};
      OP_HALT: encWord = 32'hFFFF_FFFF;
      default: encIllegal = 1'b1;
    endcase
  end

  // Next-state logic: capture in IDLE, encode in ENC, write and advance in WR.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rn_d       = rn_q;
    rm_d       = rm_q;
    imm_d      = imm_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    errOp_d    = errOp_q;
    errRange_d = errRange_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          rd_d    = bus.rd;
          rn_d    = bus.rn;
          rm_d    = bus.rm;
          imm_d   = bus.imm;
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        if (encIllegal) begin
          errOp_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          word_d = encWord;
          if (encRangeBad) begin
            errRange_d = 1'b1;
          end
          state_d = S_WR;
        end
      end
      S_WR: begin
        count_d = count_q + 1'b1;
        // The pointer is held at the last slot rather than wrapping to zero.
        if (addr_q != LAST_ADDR) begin
          addr_d = addr_q + WORD_STEP;
        end
        if ((op_q == OP_HALT) || (addr_q == LAST_ADDR)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 4'd0;
      rd_q       <= 5'd0;
      rn_q       <= 5'd0;
      rm_q       <= 5'd0;
      imm_q      <= 26'd0;
      word_q     <= 32'h0000_0000;
      addr_q     <= START_ADDR;
      count_q    <= '0;
      errOp_q    <= 1'b0;
      errRange_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      imm_q      <= imm_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      errOp_q    <= errOp_d;
      errRange_q <= errRange_d;
    end
  end

  // Handshake and strobe outputs decode directly from the registered state.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.mem_we    = (state_q == S_WR);
    bus.done      = (state_q == S_DONE);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = word_q;
    bus.count     = count_q;
    bus.err_op    = errOp_q;
    bus.err_range = errRange_q;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder. One instance uses the
// default 8-bit address space for encoding, error and reset scenarios; a
// second instance with a 4-bit address space exercises the memory-full stop.
module tb_inst_encoder;

  logic clk;
  logic reset8;
  logic reset4;
  int   checkCount;
  int   errorCount;

  inst_encoder_if #(.ADDR_W(8)) bus8 ();
  inst_encoder_if #(.ADDR_W(4)) bus4 ();

  inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .bus   (bus8.slave)
  );

  inst_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run stalls somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present an instruction to bus8, complete the handshake, and return at
  // the falling edge after the handshake edge (the DUT is then in ENC).
  task automatic applyStimulus(input logic [3:0] opIn, input logic [4:0] rdIn,
                               input logic [4:0] rnIn, input logic [4:0] rmIn,
                               input logic [25:0] immIn);
    int waitCycles;
    waitCycles    = 0;
    bus8.op       = opIn;
    bus8.rd       = rdIn;
    bus8.rn       = rnIn;
    bus8.rm       = rmIn;
    bus8.imm      = immIn;
    bus8.in_valid = 1'b1;
    while (!bus8.in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("readyAtHandshake", 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // From the ENC falling edge: no strobe yet, strobe with data one cycle
  // later, then strobe gone and count advanced.
  task automatic expectWrite(input string tag, input logic [7:0] addr,
                             input logic [31:0] word, input logic [6:0] cnt);
    checkOutput({tag, "_encNoWe"}, 32'(bus8.mem_we), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_we"}, 32'(bus8.mem_we), 32'd1);
    checkOutput({tag, "_addr"}, 32'(bus8.mem_addr), 32'(addr));
    checkOutput({tag, "_data"}, bus8.mem_wdata, word);
    checkOutput({tag, "_wrNotReady"}, 32'(bus8.in_ready), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_weOff"}, 32'(bus8.mem_we), 32'd0);
    checkOutput({tag, "_count"}, 32'(bus8.count), 32'(cnt));
  endtask

  initial begin
    int strobes;
    int writes4;
    checkCount    = 0;
    errorCount    = 0;
    reset8        = 1'b1;
    reset4        = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.op       = 4'd0;
    bus8.rd       = 5'd0;
    bus8.rn       = 5'd0;
    bus8.rm       = 5'd0;
    bus8.imm      = 26'd0;
    bus4.in_valid = 1'b0;
    bus4.op       = 4'd0;
    bus4.rd       = 5'd0;
    bus4.rn       = 5'd0;
    bus4.rm       = 5'd0;
    bus4.imm      = 26'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    checkOutput("rstReady", 32'(bus8.in_ready), 32'd1);
    checkOutput("rstWe", 32'(bus8.mem_we), 32'd0);
    checkOutput("rstAddr", 32'(bus8.mem_addr), 32'd0);
    checkOutput("rstData", bus8.mem_wdata, 32'd0);
    checkOutput("rstCount", 32'(bus8.count), 32'd0);
    checkOutput("rstDone", 32'(bus8.done), 32'd0);
    checkOutput("rstErrOp", 32'(bus8.err_op), 32'd0);
    checkOutput("rstErrRange", 32'(bus8.err_range), 32'd0);
    reset8 = 1'b0;
    @(negedge clk);

    // Formats, one at a time, at consecutive addresses
    applyStimulus(4'd2, 5'd3, 5'd1, 5'd2, 26'd0);
    expectWrite("add", 8'd0, 32'h8B02_0023, 7'd1);
    applyStimulus(4'd4, 5'd1, 5'd2, 5'd3, 26'd0);
    expectWrite("sub", 8'd4, 32'hCB03_0041, 7'd2);
    applyStimulus(4'd6, 5'd31, 5'd31, 5'd31, 26'd0);
    expectWrite("orr", 8'd8, 32'hAA1F_03FF, 7'd3);
    applyStimulus(4'd9, 5'd0, 5'd0, 5'd0, 26'h10);
    expectWrite("b", 8'd12, 32'h1400_0010, 7'd4);
    applyStimulus(4'd3, 5'd0, 5'd0, 5'd0, 26'd4095);
    expectWrite("addiMax", 8'd16, 32'h913F_FC00, 7'd5);
    applyStimulus(4'd7, 5'd1, 5'd0, 5'd0, 26'h3FF_FFFE);
    expectWrite("cbzNeg", 8'd20, 32'hB4FF_FFC1, 7'd6);
    checkOutput("cbzNegErrRange", 32'(bus8.err_range), 32'd0);
    applyStimulus(4'd8, 5'd2, 5'd0, 5'd0, 26'd5);
    expectWrite("cbnz", 8'd24, 32'hB500_00A2, 7'd7);

    // Illegal op: two cycles, no write, sticky error
    applyStimulus(4'd13, 5'd1, 5'd1, 5'd1, 26'd0);
    checkOutput("illEncNoWe", 32'(bus8.mem_we), 32'd0);
    checkOutput("illEncNotReady", 32'(bus8.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("illReadyBack", 32'(bus8.in_ready), 32'd1);
    checkOutput("illNoWe", 32'(bus8.mem_we), 32'd0);
    checkOutput("illErrOp", 32'(bus8.err_op), 32'd1);
    checkOutput("illCount", 32'(bus8.count), 32'd7);

    // ADDI out of range: truncated field, range flag
    applyStimulus(4'd3, 5'd2, 5'd3, 5'd0, 26'd5000);
    expectWrite("addiBig", 8'd28, 32'h910E_2062, 7'd8);
    checkOutput("addiBigErrRange", 32'(bus8.err_range), 32'd1);

    // Reset, then a short program ending in HALT
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    checkOutput("rst2ErrOp", 32'(bus8.err_op), 32'd0);
    checkOutput("rst2Count", 32'(bus8.count), 32'd0);
    applyStimulus(4'd0, 5'd5, 5'd2, 5'd0, 26'd8);
    expectWrite("ldur", 8'd0, 32'hF840_8045, 7'd1);
    applyStimulus(4'd1, 5'd5, 5'd2, 5'd0, 26'd16);
    expectWrite("stur", 8'd4, 32'hF801_0045, 7'd2);
    applyStimulus(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
    expectWrite("halt", 8'd8, 32'hFFFF_FFFF, 7'd3);
    checkOutput("haltDone", 32'(bus8.done), 32'd1);
    checkOutput("haltNotReady", 32'(bus8.in_ready), 32'd0);

    // DONE ignores further requests
    strobes       = 0;
    bus8.op       = 4'd2;
    bus8.in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus8.mem_we) strobes++;
    end
    bus8.in_valid = 1'b0;
    checkOutput("doneNoWrites", 32'(strobes), 32'd0);
    checkOutput("doneCountHeld", 32'(bus8.count), 32'd3);
    checkOutput("doneHeld", 32'(bus8.done), 32'd1);

    // Reset during WR drops the write and clears every flag
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    applyStimulus(4'd0, 5'd1, 5'd0, 5'd0, 26'd512);
    expectWrite("ldurBig", 8'd0, 32'hF840_0001, 7'd1);
    checkOutput("ldurBigErrRange", 32'(bus8.err_range), 32'd1);
    applyStimulus(4'd2, 5'd3, 5'd1, 5'd2, 26'd0);
    @(negedge clk);
    checkOutput("midWrWe", 32'(bus8.mem_we), 32'd1);
    reset8 = 1'b1;
    @(negedge clk);
    checkOutput("wrRstWe", 32'(bus8.mem_we), 32'd0);
    checkOutput("wrRstAddr", 32'(bus8.mem_addr), 32'd0);
    checkOutput("wrRstData", bus8.mem_wdata, 32'd0);
    checkOutput("wrRstCount", 32'(bus8.count), 32'd0);
    checkOutput("wrRstReady", 32'(bus8.in_ready), 32'd1);
    checkOutput("wrRstErrRange", 32'(bus8.err_range), 32'd0);
    checkOutput("wrRstDone", 32'(bus8.done), 32'd0);
    reset8 = 1'b0;
    @(negedge clk);

    // CB signed-fit boundary: -2^18 fits, +2^18 does not
    applyStimulus(4'd7, 5'd0, 5'd0, 5'd0, 26'h3FC_0000);
    expectWrite("cbzMinNeg", 8'd0, 32'hB480_0000, 7'd1);
    checkOutput("cbzMinNegErrRange", 32'(bus8.err_range), 32'd0);
    applyStimulus(4'd7, 5'd0, 5'd0, 5'd0, 26'h004_0000);
    expectWrite("cbzOver", 8'd4, 32'hB480_0000, 7'd2);
    checkOutput("cbzOverErrRange", 32'(bus8.err_range), 32'd1);

    // Small memory: continuous ADDs stop after four words
    writes4       = 0;
    reset4        = 1'b0;
    bus4.op       = 4'd2;
    bus4.rd       = 5'd3;
    bus4.rn       = 5'd1;
    bus4.rm       = 5'd2;
    bus4.in_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus4.mem_we) begin
        checkOutput("fullAddr", 32'(bus4.mem_addr), 32'(writes4 * 4));
        checkOutput("fullData", bus4.mem_wdata, 32'h8B02_0023);
        writes4++;
      end
    end
    bus4.in_valid = 1'b0;
    checkOutput("fullWrites", 32'(writes4), 32'd4);
    checkOutput("fullDone", 32'(bus4.done), 32'd1);
    checkOutput("fullCount", 32'(bus4.count), 32'd4);
    checkOutput("fullNotReady", 32'(bus4.in_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
